// File: rtl/ddr5_wr_pkg.sv
// Shared types and sizing helpers for the per-lane DDR5 write-data feeder.
package ddr5_wr_pkg;

    localparam int MIN_CWL   = 2;
    localparam int DEF_WIDTH = 2;
    localparam int DEF_BL    = 16;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    function automatic int beats_of(input int bl, input int width);
        return bl / width;
    endfunction

    function automatic int cnt_width_of(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int BEATS      = beats_of(DEF_BL, DEF_WIDTH);
    localparam int BEAT_CNT_W = cnt_width_of(BEATS);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a combinational head read.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; empty/full come from the pointers, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/wr_data_feeder.sv
// Per-lane write-data staging ahead of the DDR serialiser: queues bursts and WR launch
// times, then shifts each burst out WIDTH bits per clock exactly CWL cycles after its WR.
module wr_data_feeder
    import ddr5_wr_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int BL    = 16,
    parameter int DEPTH = 4,
    parameter int CWL_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [BL-1:0]    wdata_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    input  logic             wr_cmd_i,
    input  logic [CWL_W-1:0] cwl_i,
    output logic [WIDTH-1:0] data_o,
    output logic             ser_en_o,
    output logic             burst_done_o,
    output logic             underrun_o,
    output logic             cmd_ovf_o
);

    localparam int TS_W    = CWL_W + 1;
    localparam int N_BEATS = beats_of(BL, WIDTH);
    localparam int CNT_W   = cnt_width_of(N_BEATS);

    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(N_BEATS - 1);
    localparam logic [TS_W-1:0]  HALF_WINDOW = {1'b1, {CWL_W{1'b0}}};

    state_e            state_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [BL-1:0]     shifter_q;
    logic [TS_W-1:0]   now_q;
    logic [TS_W-1:0]   now_next;

    logic [CWL_W-1:0]  cwl_eff;
    logic [TS_W-1:0]   launch_ts;
    logic [TS_W-1:0]   cmd_head;
    logic              cmd_full;
    logic              cmd_empty;
    logic              cmd_pop;

    logic [BL-1:0]     data_head;
    logic              data_full;
    logic              data_empty;
    logic [BL-1:0]     load_burst;

    logic [TS_W-1:0]   head_gap;
    logic              head_due;
    logic              head_stale;
    logic              last_beat;
    logic              start;
    logic              cmd_ovf_evt;

    assign now_next  = now_q + 1'b1;
    assign cwl_eff   = (cwl_i < CWL_W'(MIN_CWL)) ? CWL_W'(MIN_CWL) : cwl_i;
    assign launch_ts = now_q + {1'b0, cwl_eff};

    sync_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .push      (wr_cmd_i),
        .push_data (launch_ts),
        .pop       (cmd_pop),
        .pop_data  (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty)
    );

    sync_fifo #(.W(BL), .DEPTH(DEPTH)) u_data_fifo (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .push      (wdata_valid_i && wdata_ready_o),
        .push_data (wdata_i),
        .pop       (start),
        .pop_data  (data_head),
        .full      (data_full),
        .empty     (data_empty)
    );

    assign wdata_ready_o = !data_full;

    // Pending launches are always less than half the timestamp window ahead, so a
    // forward distance in the upper half means the head's time has already gone by.
    assign head_gap   = cmd_head - now_next;
    assign head_due   = !cmd_empty && (head_gap == '0);
    assign head_stale = !cmd_empty && !head_due && (head_gap >= HALF_WINDOW);

    assign last_beat   = (state_q == SHIFT) && (beat_cnt_q == LAST_BEAT);
    assign start       = head_due && ((state_q == IDLE) || last_beat);
    assign cmd_pop     = start || head_stale;
    assign cmd_ovf_evt = wr_cmd_i && cmd_full && !cmd_pop;
    assign load_burst  = data_empty ? '0 : data_head;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            shifter_q    <= '0;
            now_q        <= '0;
            data_o       <= '0;
            ser_en_o     <= 1'b0;
            burst_done_o <= 1'b0;
            underrun_o   <= 1'b0;
            cmd_ovf_o    <= 1'b0;
        end else begin
            now_q <= now_next;

            if (cmd_ovf_evt)
                cmd_ovf_o <= 1'b1;
            if ((start && data_empty) || head_stale)
                underrun_o <= 1'b1;

            if (start) begin
                // Launch decided one cycle ahead so the first beat lands exactly on CWL.
                state_q      <= SHIFT;
                beat_cnt_q   <= '0;
                data_o       <= load_burst[WIDTH-1:0];
                shifter_q    <= load_burst >> WIDTH;
                ser_en_o     <= 1'b1;
                burst_done_o <= (LAST_BEAT == '0);
            end else begin
                case (state_q)
                    IDLE: begin
                        data_o       <= '0;
                        ser_en_o     <= 1'b0;
                        burst_done_o <= 1'b0;
                    end
                    SHIFT: begin
                        if (last_beat) begin
                            state_q      <= IDLE;
                            data_o       <= '0;
                            ser_en_o     <= 1'b0;
                            burst_done_o <= 1'b0;
                        end else begin
                            beat_cnt_q   <= beat_cnt_q + 1'b1;
                            data_o       <= shifter_q[WIDTH-1:0];
                            shifter_q    <= shifter_q >> WIDTH;
                            ser_en_o     <= 1'b1;
                            burst_done_o <= ((beat_cnt_q + 1'b1) == LAST_BEAT);
                        end
                    end
                    default: begin
                        state_q      <= IDLE;
                        data_o       <= '0;
                        ser_en_o     <= 1'b0;
                        burst_done_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wr_data_feeder.sv
// Directed bench for wr_data_feeder: latency, beat order, back-to-back bursts,
// underrun, command overflow, minimum CWL clamp and asynchronous reset mid-burst.
module tb_wr_data_feeder;

    localparam int WIDTH = 2;
    localparam int BL    = 16;
    localparam int DEPTH = 4;
    localparam int CWL_W = 6;

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic [BL-1:0]    wdata_i = '0;
    logic             wdata_valid_i = 1'b0;
    logic             wdata_ready_o;
    logic             wr_cmd_i = 1'b0;
    logic [CWL_W-1:0] cwl_i = '0;
    logic [WIDTH-1:0] data_o;
    logic             ser_en_o;
    logic             burst_done_o;
    logic             underrun_o;
    logic             cmd_ovf_o;

    int n_checks = 0;
    int n_fail   = 0;

    wr_data_feeder #(.WIDTH(WIDTH), .BL(BL), .DEPTH(DEPTH), .CWL_W(CWL_W)) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .wdata_i       (wdata_i),
        .wdata_valid_i (wdata_valid_i),
        .wdata_ready_o (wdata_ready_o),
        .wr_cmd_i      (wr_cmd_i),
        .cwl_i         (cwl_i),
        .data_o        (data_o),
        .ser_en_o      (ser_en_o),
        .burst_done_o  (burst_done_o),
        .underrun_o    (underrun_o),
        .cmd_ovf_o     (cmd_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance into the next clock period; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        wdata_valid_i = 1'b0;
        wr_cmd_i      = 1'b0;
        cwl_i         = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        step();
    endtask

    task automatic push(input logic [BL-1:0] d);
        wdata_i       = d;
        wdata_valid_i = 1'b1;
        step();
        wdata_valid_i = 1'b0;
    endtask

    task automatic wr(input int cwl);
        wr_cmd_i = 1'b1;
        cwl_i    = CWL_W'(cwl);
        step();
        wr_cmd_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // 0xA5C3 split into 2-bit beats from bit 0 upward: 0xC3 -> 3,0,0,3 ; 0xA5 -> 1,1,2,2.
    logic [1:0]    exp_a5c3 [8] = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [BL-1:0] bursts   [4] = '{16'h1234, 16'hF00F, 16'h8001, 16'h5AA5};

    initial begin
        int en_cnt;
        int done_cnt;
        int data_or;
        logic [BL-1:0] b;
        int k;

        // 1: idle after reset
        do_reset();
        en_cnt = 0; done_cnt = 0; data_or = 0;
        for (int i = 0; i < 20; i++) begin
            en_cnt   += int'(ser_en_o);
            done_cnt += int'(burst_done_o);
            data_or  |= int'(data_o);
            step();
        end
        check("t1_ser_en_cycles", en_cnt, 0);
        check("t1_done_cycles", done_cnt, 0);
        check("t1_data_or", data_or, 0);
        check("t1_ready", wdata_ready_o, 1);
        check("t1_underrun", underrun_o, 0);
        check("t1_cmd_ovf", cmd_ovf_o, 0);

        // 2: single burst, cwl=5, WR held in period P -> beats in P+5..P+12
        do_reset();
        push(16'hA5C3);
        wr(5);
        repeat (3) step();
        check("t2_pre_launch_en", ser_en_o, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_en_beat%0d", i), ser_en_o, 1);
            check($sformatf("t2_data_beat%0d", i), data_o, exp_a5c3[i]);
            check($sformatf("t2_done_beat%0d", i), burst_done_o, (i == 7));
            step();
        end
        check("t2_post_en", ser_en_o, 0);
        check("t2_post_data", data_o, 0);
        check("t2_post_done", burst_done_o, 0);
        check("t2_underrun", underrun_o, 0);

        // 3: four queued bursts, WR every 8 cycles with cwl=6 -> 32 contiguous beats
        do_reset();
        for (int j = 0; j < 4; j++) push(bursts[j]);
        check("t3_ready_full", wdata_ready_o, 0);
        en_cnt = 0; done_cnt = 0;
        cwl_i = CWL_W'(6);
        for (int i = 0; i < 42; i++) begin
            wr_cmd_i = ((i % 8) == 0) && (i < 32);
            check($sformatf("t3_en_p%0d", i), ser_en_o, (i >= 6) && (i < 38));
            if (i >= 6 && i < 38) begin
                b = bursts[(i - 6) / 8];
                k = (i - 6) % 8;
                check($sformatf("t3_data_p%0d", i), data_o, b[k*WIDTH +: WIDTH]);
                check($sformatf("t3_done_p%0d", i), burst_done_o, (k == 7));
            end
            en_cnt   += int'(ser_en_o);
            done_cnt += int'(burst_done_o);
            step();
        end
        wr_cmd_i = 1'b0;
        check("t3_en_total", en_cnt, 32);
        check("t3_done_total", done_cnt, 4);
        check("t3_ready_after", wdata_ready_o, 1);
        check("t3_underrun", underrun_o, 0);

        // 4: launch with empty data FIFO -> zero beats, sticky underrun
        do_reset();
        en_cnt = 0; data_or = 0;
        cwl_i = CWL_W'(4);
        for (int i = 0; i < 16; i++) begin
            wr_cmd_i = (i == 0);
            if (i == 3) check("t4_underrun_before", underrun_o, 0);
            if (i >= 4 && i < 12) check($sformatf("t4_en_p%0d", i), ser_en_o, 1);
            en_cnt  += int'(ser_en_o);
            data_or |= int'(data_o);
            step();
        end
        wr_cmd_i = 1'b0;
        check("t4_en_total", en_cnt, 8);
        check("t4_data_or", data_or, 0);
        check("t4_underrun", underrun_o, 1);
        repeat (10) step();
        check("t4_underrun_sticky", underrun_o, 1);

        // 5: five WRs at cwl=40 before any launch -> fifth dropped, 4 bursts only
        do_reset();
        for (int j = 0; j < 4; j++) push(bursts[j]);
        en_cnt = 0; done_cnt = 0;
        cwl_i = CWL_W'(40);
        for (int i = 0; i < 100; i++) begin
            wr_cmd_i = ((i % 8) == 0) && (i <= 32);
            if (i == 32) check("t5_ovf_before", cmd_ovf_o, 0);
            if (i == 33) check("t5_ovf_set", cmd_ovf_o, 1);
            if (i == 40) check("t5_first_beat", data_o, bursts[0][1:0]);
            en_cnt   += int'(ser_en_o);
            done_cnt += int'(burst_done_o);
            step();
        end
        wr_cmd_i = 1'b0;
        check("t5_en_total", en_cnt, 32);
        check("t5_done_total", done_cnt, 4);
        check("t5_cmd_ovf", cmd_ovf_o, 1);
        check("t5_underrun", underrun_o, 0);

        // cwl below minimum is clamped to 2
        do_reset();
        push(16'h0002);
        wr(1);
        check("tmin_not_yet", ser_en_o, 0);
        step();
        check("tmin_en", ser_en_o, 1);
        check("tmin_data", data_o, 2);
        check("tmin_underrun", underrun_o, 0);
        repeat (10) step();

        // 6: asynchronous reset at beat 3 of a burst
        do_reset();
        push(16'hFFFF);
        wr(3);
        repeat (2) step();
        check("t6_beat0_en", ser_en_o, 1);
        repeat (3) step();
        check("t6_beat3_en", ser_en_o, 1);
        check("t6_beat3_data", data_o, 3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_en", ser_en_o, 0);
        check("t6_rst_data", data_o, 0);
        check("t6_rst_done", burst_done_o, 0);
        @(negedge clk_i);
        rst_n = 1'b1;
        step();
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            en_cnt += int'(ser_en_o);
            step();
        end
        check("t6_no_residual", en_cnt, 0);
        check("t6_ready", wdata_ready_o, 1);
        check("t6_underrun_clear", underrun_o, 0);
        // Data FIFO must have been flushed: a fresh launch finds nothing queued.
        wr(2);
        step();
        check("t6_relaunch_en", ser_en_o, 1);
        check("t6_relaunch_data", data_o, 0);
        check("t6_relaunch_underrun", underrun_o, 1);
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
